// File: rtl/reservoir_sequencer.sv
// Sequencer that feeds masked samples into the delayed-feedback reservoir one
// virtual node per clock and records every reservoir output into state memory.
module reservoir_sequencer #(
  parameter int VIRTUAL_NODES    = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int STATE_ADDR_WIDTH = 20,
  parameter int RES_LATENCY      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       num_samples,
  input  logic [VIRTUAL_NODES-1:0]    mask_bits,
  output logic                        busy,
  output logic                        done,
  output logic                        sample_rd_en,
  output logic [ADDR_WIDTH-1:0]       sample_addr,
  input  logic [DATA_WIDTH-1:0]       sample_rd_data,
  output logic [DATA_WIDTH-1:0]       res_din,
  input  logic [DATA_WIDTH-1:0]       res_dout,
  output logic                        state_wr_en,
  output logic [STATE_ADDR_WIDTH-1:0] state_wr_addr,
  output logic [DATA_WIDTH-1:0]       state_wr_data,
  output logic [2:0]                  fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_INJECT = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int NW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;
  localparam logic [NW-1:0] LAST_NODE = NW'(VIRTUAL_NODES - 1);
  localparam logic [NW-1:0] PRE_NODE  = NW'(VIRTUAL_NODES - 2);

  logic [2:0]               state;
  logic [NW-1:0]            node;
  logic [NW-1:0]            node_nxt;
  logic [ADDR_WIDTH-1:0]    smp;
  logic [ADDR_WIDTH:0]      smp_nxt;
  logic [ADDR_WIDTH-1:0]    num_r;
  logic [VIRTUAL_NODES-1:0] mask_r;
  logic [DATA_WIDTH-1:0]    cur_sample;
  logic [RES_LATENCY-1:0]   vld_pipe;
  logic [RES_LATENCY-1:0]   vld_shift;
  logic                     presenting;
  logic                     more;
  logic                     prefetch;

  function automatic logic [DATA_WIDTH-1:0] apply_mask(input logic [DATA_WIDTH-1:0] x,
                                                       input logic pos);
    return pos ? x : DATA_WIDTH'(-x);
  endfunction

  // Read strobes are fire-and-forget: sample_rd_en with sample_addr in cycle t
  // means sample_rd_data is valid in cycle t+1; the memory never stalls.
  always_comb begin
    node_nxt     = node + NW'(1);
    smp_nxt      = {1'b0, smp} + 1'b1;
    more         = smp_nxt < {1'b0, num_r};
    presenting   = (state == S_INJECT);
    prefetch     = presenting && (node == PRE_NODE) && more;
    sample_rd_en = (state == S_FETCH) || prefetch;
    sample_addr  = prefetch ? smp_nxt[ADDR_WIDTH-1:0] : '0;
    busy         = (state == S_FETCH) || (state == S_LOAD) ||
                   (state == S_INJECT) || (state == S_DRAIN);
    done         = (state == S_DONE);
    state_wr_en  = vld_pipe[RES_LATENCY-1];
    state_wr_data = state_wr_en ? res_dout : '0;
    vld_shift    = vld_pipe << 1;
    fsm_state    = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      node          <= '0;
      smp           <= '0;
      num_r         <= '0;
      mask_r        <= '0;
      cur_sample    <= '0;
      res_din       <= '0;
      vld_pipe      <= '0;
      state_wr_addr <= '0;
    end else begin
      vld_pipe <= vld_shift | RES_LATENCY'(presenting);
      if (state_wr_en) state_wr_addr <= state_wr_addr + 1'b1;
      case (state)
        S_IDLE: begin
          res_din <= '0;
          if (start) begin
            if (num_samples != '0) begin
              num_r         <= num_samples;
              mask_r        <= mask_bits;
              smp           <= '0;
              node          <= '0;
              state_wr_addr <= '0;
              state         <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          cur_sample <= sample_rd_data;
          res_din    <= apply_mask(sample_rd_data, mask_r[0]);
          node       <= '0;
          state      <= S_INJECT;
        end
        S_INJECT: begin
          if (node != LAST_NODE) begin
            node    <= node_nxt;
            res_din <= apply_mask(cur_sample, mask_r[node_nxt]);
          end else begin
            node <= '0;
            // Prefetched data lands exactly now, so the next sample starts gap-free.
            if (more) begin
              smp        <= smp_nxt[ADDR_WIDTH-1:0];
              cur_sample <= sample_rd_data;
              res_din    <= apply_mask(sample_rd_data, mask_r[0]);
            end else begin
              res_din <= '0;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          res_din <= '0;
          if (vld_shift == '0) state <= S_DONE;
        end
        S_DONE: begin
          res_din <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Self-checking bench for reservoir_sequencer: one instance with RES_LATENCY=1,
// one with RES_LATENCY=3, stub reservoirs and a write scoreboard per instance.
module tb_reservoir_sequencer;
  localparam int VN  = 10;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int SAW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [0:63];

  // Instance A, latency 1
  logic           rst, start, busy, done, sample_rd_en, state_wr_en;
  logic [AW-1:0]  num_samples, sample_addr;
  logic [VN-1:0]  mask_bits;
  logic [DW-1:0]  sample_rd_data, res_din, res_dout, state_wr_data;
  logic [SAW-1:0] state_wr_addr;
  logic [2:0]     fsm_state;

  // Instance B, latency 3
  logic           rst_b, start_b, busy_b, done_b, sample_rd_en_b, state_wr_en_b;
  logic [AW-1:0]  num_samples_b, sample_addr_b;
  logic [VN-1:0]  mask_bits_b;
  logic [DW-1:0]  sample_rd_data_b, res_din_b, res_dout_b, state_wr_data_b;
  logic [SAW-1:0] state_wr_addr_b;
  logic [2:0]     fsm_state_b;
  logic [DW-1:0]  dly_b [3];

  reservoir_sequencer #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .STATE_ADDR_WIDTH(SAW), .RES_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .mask_bits(mask_bits),
    .busy(busy), .done(done), .sample_rd_en(sample_rd_en), .sample_addr(sample_addr),
    .sample_rd_data(sample_rd_data), .res_din(res_din), .res_dout(res_dout),
    .state_wr_en(state_wr_en), .state_wr_addr(state_wr_addr), .state_wr_data(state_wr_data),
    .fsm_state(fsm_state));

  reservoir_sequencer #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .STATE_ADDR_WIDTH(SAW), .RES_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .num_samples(num_samples_b), .mask_bits(mask_bits_b),
    .busy(busy_b), .done(done_b), .sample_rd_en(sample_rd_en_b), .sample_addr(sample_addr_b),
    .sample_rd_data(sample_rd_data_b), .res_din(res_din_b), .res_dout(res_dout_b),
    .state_wr_en(state_wr_en_b), .state_wr_addr(state_wr_addr_b), .state_wr_data(state_wr_data_b),
    .fsm_state(fsm_state_b));

  // Sample memories and stub reservoirs (pure delay lines)
  always @(posedge clk) begin
    if (sample_rd_en)   sample_rd_data   <= mem[sample_addr[5:0]];
    if (sample_rd_en_b) sample_rd_data_b <= mem[sample_addr_b[5:0]];
    res_dout <= res_din;
    dly_b[0] <= res_din_b;
    dly_b[1] <= dly_b[0];
    dly_b[2] <= dly_b[1];
  end
  assign res_dout_b = dly_b[2];

  function automatic logic [DW-1:0] node_val(input logic [DW-1:0] x, input logic pos);
    return pos ? x : (~x + 32'd1);
  endfunction

  // Write scoreboards: {addr, data} expected per write, popped in order
  logic [SAW+DW-1:0] exp_q[$];
  logic [SAW+DW-1:0] exp_q_b[$];
  int wr_cnt = 0;
  int wr_cnt_b = 0;

  always @(negedge clk) begin
    logic [SAW+DW-1:0] w;
    if (state_wr_en === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected write addr=%0h data=%h", state_wr_addr, state_wr_data);
      end else begin
        w = exp_q.pop_front();
        if ({state_wr_addr, state_wr_data} !== w) begin
          errors++;
          $display("FAIL wr_a got addr=%0h data=%h exp addr=%0h data=%h",
                   state_wr_addr, state_wr_data, w[SAW+DW-1:DW], w[DW-1:0]);
        end
      end
    end
    if (state_wr_en_b === 1'b1) begin
      wr_cnt_b++;
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected write addr=%0h data=%h", state_wr_addr_b, state_wr_data_b);
      end else begin
        w = exp_q_b.pop_front();
        if ({state_wr_addr_b, state_wr_data_b} !== w) begin
          errors++;
          $display("FAIL wr_b got addr=%0h data=%h exp addr=%0h data=%h",
                   state_wr_addr_b, state_wr_data_b, w[SAW+DW-1:DW], w[DW-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", done); end
    checks++; if (sample_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en got=%b exp=0", sample_rd_en); end
    checks++; if (sample_addr !== '0) begin errors++; $display("FAIL reset sample_addr got=%h exp=0", sample_addr); end
    checks++; if (res_din !== '0) begin errors++; $display("FAIL reset res_din got=%h exp=0", res_din); end
    checks++; if (state_wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en got=%b exp=0", state_wr_en); end
    checks++; if (state_wr_addr !== '0) begin errors++; $display("FAIL reset wr_addr got=%h exp=0", state_wr_addr); end
    checks++; if (state_wr_data !== '0) begin errors++; $display("FAIL reset wr_data got=%h exp=0", state_wr_data); end
    checks++;
    if ({busy_b, done_b, sample_rd_en_b, sample_addr_b, res_din_b, state_wr_en_b, state_wr_addr_b} !== '0) begin
      errors++; $display("FAIL reset_b outputs got nonzero busy=%b res_din=%h exp all 0", busy_b, res_din_b);
    end
  endtask

  // Full run on instance A with cycle-exact expectations relative to the start cycle
  task automatic run_and_check(input string name, input int n, input logic [VN-1:0] m);
    int last, idx;
    logic [DW-1:0] exp_din;
    logic exp_rd, exp_wr, exp_done, exp_busy;
    logic [AW-1:0] exp_ad;
    for (int s = 0; s < n; s++)
      for (int k = 0; k < VN; k++)
        exp_q.push_back({SAW'(s * VN + k), node_val(mem[s], m[k])});
    last = n * VN + 2;
    @(negedge clk);
    start = 1'b1; num_samples = AW'(n); mask_bits = m;
    for (int rel = 1; rel <= last + 6; rel++) begin
      @(negedge clk);
      if (rel == 1) start = 1'b0;
      exp_rd = ((rel - 1) % VN == 0) && ((rel - 1) / VN < n);
      exp_ad = AW'((rel - 1) / VN);
      exp_din = '0;
      if (rel >= 3 && rel <= last) begin
        idx = rel - 3;
        exp_din = node_val(mem[idx / VN], m[idx % VN]);
      end
      exp_wr   = (rel >= 4 && rel <= last + 1);
      exp_done = (rel == last + 2);
      exp_busy = (rel >= 1 && rel <= last + 1);
      checks++;
      if (sample_rd_en !== exp_rd || (exp_rd && sample_addr !== exp_ad)) begin
        errors++;
        $display("FAIL %s rd rel=%0d got en=%b addr=%0h exp en=%b addr=%0h",
                 name, rel, sample_rd_en, sample_addr, exp_rd, exp_ad);
      end
      checks++;
      if (res_din !== exp_din) begin
        errors++; $display("FAIL %s res_din rel=%0d got=%h exp=%h", name, rel, res_din, exp_din);
      end
      checks++;
      if (state_wr_en !== exp_wr) begin
        errors++; $display("FAIL %s wr_en rel=%0d got=%b exp=%b", name, rel, state_wr_en, exp_wr);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL %s done rel=%0d got=%b exp=%b", name, rel, done, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL %s busy rel=%0d got=%b exp=%b", name, rel, busy, exp_busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s pending writes got=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single();
    mem[0] = 32'h028F5C29;
    run_and_check("single", 1, 10'b1010101010);
  endtask

  task automatic test_multi();
    for (int i = 0; i < 3; i++) mem[i] = $urandom;
    run_and_check("multi", 3, VN'($urandom_range(0, 1023)));
  endtask

  task automatic test_mask_edges();
    mem[0] = 32'h80000000; mem[1] = 32'h00000001; mem[2] = 32'h00000000;
    run_and_check("mask_neg", 3, '0);
    run_and_check("mask_pos", 3, '1);
  endtask

  task automatic test_zero();
    int base;
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1; num_samples = '0; mask_bits = '1;
    for (int rel = 1; rel <= 6; rel++) begin
      @(negedge clk);
      if (rel == 1) start = 1'b0;
      checks++;
      if (done !== (rel == 1)) begin errors++; $display("FAIL zero done rel=%0d got=%b", rel, done); end
      checks++;
      if ({busy, sample_rd_en, state_wr_en} !== 3'b000) begin
        errors++; $display("FAIL zero busy/rd/wr rel=%0d got=%b%b%b exp=000", rel, busy, sample_rd_en, state_wr_en);
      end
    end
    checks++;
    if (wr_cnt != base) begin errors++; $display("FAIL zero writes got=%0d exp=0", wr_cnt - base); end
  endtask

  task automatic test_reset_midrun();
    int base;
    for (int i = 0; i < 3; i++) mem[i] = $urandom;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < VN; k++)
        exp_q.push_back({SAW'(s * VN + k), node_val(mem[s], 1'b1)});
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1; num_samples = AW'(3); mask_bits = '1;
    for (int rel = 1; rel <= 18; rel++) begin
      @(negedge clk);
      if (rel == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sample_rd_en, sample_addr, res_din, state_wr_en, state_wr_addr, state_wr_data} !== '0) begin
      errors++;
      $display("FAIL midrst outputs got busy=%b res_din=%h wr_en=%b wr_addr=%h exp all 0",
               busy, res_din, state_wr_en, state_wr_addr);
    end
    checks++;
    if (wr_cnt - base != 15) begin errors++; $display("FAIL midrst writes got=%0d exp=15", wr_cnt - base); end
    rst = 1'b0;
    exp_q.delete();
    mem[0] = 32'h13572468;
    run_and_check("restart", 1, 10'b0110011001);
  endtask

  task automatic test_back_to_back();
    logic exp_wr, exp_busy, exp_rd;
    mem[0] = 32'hCAFE0001; mem[1] = 32'h7FFFFFFF;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < VN; k++)
        exp_q_b.push_back({SAW'(s * VN + k), node_val(mem[s], k[0])});
    @(negedge clk);
    start_b = 1'b1; num_samples_b = AW'(2); mask_bits_b = 10'b1010101010;
    for (int rel = 1; rel <= 28; rel++) begin
      @(negedge clk);
      exp_wr   = (rel >= 6 && rel <= 25);
      exp_busy = (rel >= 1 && rel <= 25) || rel == 28;
      exp_rd   = (rel == 1 || rel == 11 || rel == 28);
      checks++;
      if (state_wr_en_b !== exp_wr) begin errors++; $display("FAIL b2b wr_en rel=%0d got=%b exp=%b", rel, state_wr_en_b, exp_wr); end
      checks++;
      if (done_b !== (rel == 26)) begin errors++; $display("FAIL b2b done rel=%0d got=%b", rel, done_b); end
      checks++;
      if (busy_b !== exp_busy) begin errors++; $display("FAIL b2b busy rel=%0d got=%b exp=%b", rel, busy_b, exp_busy); end
      checks++;
      if (sample_rd_en_b !== exp_rd) begin errors++; $display("FAIL b2b rd_en rel=%0d got=%b exp=%b", rel, sample_rd_en_b, exp_rd); end
    end
    checks++;
    if (wr_cnt_b != 20 || exp_q_b.size() != 0) begin
      errors++; $display("FAIL b2b writes got=%0d pending=%0d exp 20/0", wr_cnt_b, exp_q_b.size());
    end
    rst_b = 1'b1; start_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    exp_q_b.delete();
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    start = 1'b0; num_samples = '0; mask_bits = '0;
    start_b = 1'b0; num_samples_b = '0; mask_bits_b = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0; rst_b = 1'b0;
    test_single();
    test_multi();
    test_zero();
    test_mask_edges();
    test_reset_midrun();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reservoir_sequencer.md
# reservoir_sequencer

Controller that drives the delayed-feedback `reservoir` datapath from a sample memory and records the resulting virtual-node states.
- On `start`, it reads N input samples and applies a per-node ±1 input mask to each sample.
- It streams the masked values into the reservoir one virtual node per clock, with no gaps between samples.
- It writes every reservoir output into a linear state memory for the readout layer.
- It sits between the host/config registers, the sample and state memories, and the `reservoir` instance.

## Interface
Parameters:
- `VIRTUAL_NODES`, 10, nodes per sample; must be ≥ 2.
- `DATA_WIDTH`, 32, sample and reservoir data width (two's complement).
- `ADDR_WIDTH`, 16, sample memory address width; also the width of `num_samples`.
- `STATE_ADDR_WIDTH`, 20, state memory address width.
- `RES_LATENCY`, 1, cycles from a value on `res_din` to its result on `res_dout`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `num_samples`  in  ADDR_WIDTH  number of samples to process; latched on an accepted `start`.
- `mask_bits`  in  VIRTUAL_NODES  input mask, latched on an accepted `start`; bit k=1 gives +sample, bit k=0 gives −sample.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `sample_rd_en`  out  1  sample memory read strobe.
- `sample_addr`  out  ADDR_WIDTH  sample read address.
- `sample_rd_data`  in  DATA_WIDTH  valid the cycle after `sample_rd_en`.
- `res_din`  out  DATA_WIDTH  registered input to the reservoir.
- `res_dout`  in  DATA_WIDTH  reservoir output.
- `state_wr_en`  out  1  state memory write strobe.
- `state_wr_addr`  out  STATE_ADDR_WIDTH  state write address.
- `state_wr_data`  out  DATA_WIDTH  state write data; equals `res_dout` in the write cycle.

## Operation
- FSM states: IDLE, FETCH, LOAD, INJECT, DRAIN, DONE.
- IDLE:
  - `start`=1 with `num_samples`≠0: latch `num_samples` and `mask_bits`, go to FETCH.
  - `start`=1 with `num_samples`=0: go to DONE; no reads or writes occur and `busy` stays 0.
- FETCH (1 cycle): `sample_rd_en`=1, `sample_addr`=0.
- LOAD (1 cycle): capture `sample_rd_data`; load `res_din` with node 0 of that sample.
- INJECT, per cycle:
  - `res_din` holds the masked value for node k of sample s.
  - Node counter wraps VIRTUAL_NODES−1 → 0 and increments s.
- Prefetch: in the cycle where node VIRTUAL_NODES−2 is presented and s+1 < N, issue `sample_rd_en` with `sample_addr`=s+1. The data arrives in the node VIRTUAL_NODES−1 cycle, so node 0 of s+1 follows with no gap.
- Masking: +x or the two's complement −x, truncated to DATA_WIDTH. −(0x8000_0000) = 0x8000_0000.
- After the last node of sample N−1, go to DRAIN; `res_din` returns to 0.
- DRAIN: wait until all in-flight captures are written, then go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0, then return to IDLE.
- Capture path:
  - A RES_LATENCY-deep valid shift register tracks presented nodes.
  - A node presented in cycle t is written in cycle t+RES_LATENCY with `state_wr_data`=`res_dout`.
  - `state_wr_addr` starts at 0 per run, increments after each write, and wraps modulo 2^STATE_ADDR_WIDTH.
- `res_din`=0 whenever no node is being presented: IDLE, FETCH, DRAIN, DONE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `sample_rd_en`, `sample_addr`, `res_din`, `state_wr_en`, `state_wr_addr`, `state_wr_data`); FSM in IDLE; counters and the valid pipe cleared.
- `rst` mid-run takes effect the next cycle: the run is aborted, in-flight writes are dropped, and no `done` is produced. A new `start` after reset begins again at address 0.
- Cycle map with `start` accepted in cycle 0:
  - FETCH in cycle 1.
  - Node 0 of sample 0 on `res_din` in cycle 3.
  - Last node in cycle N·VN+2.
  - Last write in cycle N·VN+2+RES_LATENCY.
  - `done` in cycle N·VN+RES_LATENCY+3.
- `busy`=1 from cycle 1 through the last write cycle.
- Read for sample s (s≥1) is issued in cycle 3+s·VN−2.
- Exactly N·VN writes per run, on consecutive cycles.

## Test plan
Defaults VN=10, RES_LATENCY=1; the reservoir is a stub whose `res_dout` is `res_din` delayed by RES_LATENCY.
- N=1, sample[0]=0x028F5C29, mask=10'b1010101010 → `res_din` in cycles 3..12 alternates 0xFD70A3D7, 0x028F5C29, … (starting with node 0 = −x); writes to addresses 0..9 in cycles 4..13; `done` in cycle 14.
- N=3 → reads at addresses 0,1,2 in cycles 1,11,21; 30 gap-free `res_din` cycles (3..32); 30 writes; `done` in cycle 34.
- `num_samples`=0 → `done` in cycle 1; no `sample_rd_en`; no `state_wr_en`; `busy` never 1.
- sample=0x80000000 with mask bit 0 → 0x80000000; sample=1 with mask bit 0 → 0xFFFFFFFF; sample=0 → 0.
- `rst` pulsed in the cycle of node 5 of sample 1 → next cycle all outputs 0; restarting with N=1 writes from address 0; `done` exactly 14 cycles after the new `start`.
- RES_LATENCY=3, N=2, `start` held high throughout → one run only; last write in cycle 25; `done` in cycle 26; a second run begins only after `done`.
